// File: rtl/modn_counter.sv
// Modulo-MODULUS up/down counter with clock prescaler, synchronous parallel
// load, one-cycle wrap/borrow pulse and active-low seven-segment decode.
module modn_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 8,
  parameter int DIV     = 1
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             iEn,
  input  logic             iUp,
  input  logic             iLoad,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oQ,
  output logic             oCarry,
  output logic [6:0]       oDisplay
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(MODULUS - 1);
  localparam logic [PW-1:0]    PMAX = PW'(DIV - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic             carry_q, carry_d;
  logic             step;

  assign step = iEn && (pcnt_q == PMAX);

  always_comb begin
    q_d     = q_q;
    pcnt_d  = pcnt_q;
    carry_d = 1'b0;
    if (iLoad) begin
      // Out-of-range load values saturate so the count never leaves 0..MODULUS-1.
      q_d    = (iData > QMAX) ? QMAX : iData;
      pcnt_d = '0;
    end else if (step) begin
      pcnt_d = '0;
      if (iUp) begin
        if (q_q == QMAX) begin
          q_d     = '0;
          carry_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d     = QMAX;
          carry_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end else if (iEn) begin
      pcnt_d = pcnt_q + PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      pcnt_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      pcnt_q  <= pcnt_d;
      carry_q <= carry_d;
    end
  end

  assign oQ     = q_q;
  assign oCarry = carry_q;

  logic [3:0] nib;
  generate
    if (WIDTH >= 4) begin : g_nib_wide
      assign nib = q_q[3:0];
    end else begin : g_nib_narrow
      assign nib = {{(4 - WIDTH){1'b0}}, q_q};
    end
  endgenerate

  // Segment order g..a, active-low.
  always_comb begin
    oDisplay = 7'b1111111;
    case (nib)
      4'h0: oDisplay = 7'b1000000;
      4'h1: oDisplay = 7'b1111001;
      4'h2: oDisplay = 7'b0100100;
      4'h3: oDisplay = 7'b0110000;
      4'h4: oDisplay = 7'b0011001;
      4'h5: oDisplay = 7'b0010010;
      4'h6: oDisplay = 7'b0000010;
      4'h7: oDisplay = 7'b1111000;
      4'h8: oDisplay = 7'b0000000;
      4'h9: oDisplay = 7'b0010000;
      4'hA: oDisplay = 7'b0001000;
      4'hB: oDisplay = 7'b0000011;
      4'hC: oDisplay = 7'b1000110;
      4'hD: oDisplay = 7'b0100001;
      4'hE: oDisplay = 7'b0000110;
      4'hF: oDisplay = 7'b0001110;
      default: oDisplay = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_modn_counter.sv
// Directed bench for modn_counter: three instances cover mod-8/DIV=1,
// mod-10/DIV=1 and mod-10/DIV=4 behaviour.
module tb_modn_counter;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  // A: WIDTH=3 MODULUS=8 DIV=1
  logic a_en = 0, a_up = 1, a_load = 0;
  logic [2:0] a_data = '0, a_q;
  logic a_c;
  logic [6:0] a_d;
  // B: WIDTH=4 MODULUS=10 DIV=1
  logic b_en = 0, b_up = 1, b_load = 0;
  logic [3:0] b_data = '0, b_q;
  logic b_c;
  logic [6:0] b_d;
  // C: WIDTH=4 MODULUS=10 DIV=4
  logic c_en = 0, c_up = 1, c_load = 0;
  logic [3:0] c_data = '0, c_q;
  logic c_c;
  logic [6:0] c_d;

  modn_counter #(.WIDTH(3), .MODULUS(8), .DIV(1)) u_a (
    .CLK(CLK), .rst_n(rst_n), .iEn(a_en), .iUp(a_up), .iLoad(a_load),
    .iData(a_data), .oQ(a_q), .oCarry(a_c), .oDisplay(a_d));
  modn_counter #(.WIDTH(4), .MODULUS(10), .DIV(1)) u_b (
    .CLK(CLK), .rst_n(rst_n), .iEn(b_en), .iUp(b_up), .iLoad(b_load),
    .iData(b_data), .oQ(b_q), .oCarry(b_c), .oDisplay(b_d));
  modn_counter #(.WIDTH(4), .MODULUS(10), .DIV(4)) u_c (
    .CLK(CLK), .rst_n(rst_n), .iEn(c_en), .iUp(c_up), .iLoad(c_load),
    .iData(c_data), .oQ(c_q), .oCarry(c_c), .oDisplay(c_d));

  logic [6:0] seg [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000};

  task automatic do_reset();
    @(negedge CLK);
    rst_n = 0;
    a_en = 0; b_en = 0; c_en = 0;
    a_load = 0; b_load = 0; c_load = 0;
    a_up = 1; b_up = 1; c_up = 1;
    @(negedge CLK);
    @(negedge CLK);
    rst_n = 1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    rst_n = 0;
    a_en = 1; a_up = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      n_chk++;
      if ({a_q, a_c, a_d} !== {3'd0, 1'b0, 7'b1000000}) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: q=%0d c=%b d=%b want q=0 c=0 d=1000000", i, a_q, a_c, a_d);
      end
    end
    rst_n = 1;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (a_q !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_release_count: q=%0d want 3", a_q);
    end
    @(posedge CLK);
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({a_q, a_c, a_d} !== {3'd0, 1'b0, 7'b1000000}) begin
      n_fail++;
      $display("FAIL reset_async: q=%0d c=%b d=%b want q=0 c=0 d=1000000", a_q, a_c, a_d);
    end
    @(negedge CLK);
    rst_n = 1;
    a_en = 0;
  endtask

  task automatic test_up_wrap();
    logic [2:0] exp_q [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    logic       exp_c [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    a_en = 1; a_up = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_chk++;
      if ({a_q, a_c} !== {exp_q[i], exp_c[i]}) begin
        n_fail++;
        $display("FAIL up_wrap step%0d: q=%0d c=%b want q=%0d c=%b", i, a_q, a_c, exp_q[i], exp_c[i]);
      end
      if (i == 6) begin
        n_chk++;
        if (a_d !== 7'b1111000) begin
          n_fail++;
          $display("FAIL up_wrap_disp7: d=%b want 1111000", a_d);
        end
      end
    end
    a_en = 0;
  endtask

  task automatic test_down_borrow();
    logic [3:0] exp_q [11] = '{4'd9, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd9};
    do_reset();
    b_en = 1; b_up = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge CLK);
      n_chk++;
      if ({b_q, b_c} !== {exp_q[i], exp_q[i] == 4'd9}) begin
        n_fail++;
        $display("FAIL down_borrow step%0d: q=%0d c=%b want q=%0d c=%b", i, b_q, b_c, exp_q[i], exp_q[i] == 4'd9);
      end
      if (i == 0) begin
        n_chk++;
        if (b_d !== 7'b0010000) begin
          n_fail++;
          $display("FAIL down_disp9: d=%b want 0010000", b_d);
        end
      end
    end
    b_en = 0;
  endtask

  task automatic test_prescaler();
    logic [3:0] exp_q [8] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd2};
    do_reset();
    c_en = 1; c_up = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      n_chk++;
      if ({c_q, c_c} !== {exp_q[i], 1'b0}) begin
        n_fail++;
        $display("FAIL prescale edge%0d: q=%0d c=%b want q=%0d c=0", i + 1, c_q, c_c, exp_q[i]);
      end
    end
    repeat (2) @(negedge CLK);
    c_en = 0;
    repeat (5) @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd2) begin
      n_fail++;
      $display("FAIL prescale_hold: q=%0d want 2", c_q);
    end
    c_en = 1;
    @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd2) begin
      n_fail++;
      $display("FAIL prescale_resume1: q=%0d want 2", c_q);
    end
    @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd3) begin
      n_fail++;
      $display("FAIL prescale_resume2: q=%0d want 3", c_q);
    end
  endtask

  task automatic test_load();
    logic [3:0] ld_in  [4] = '{4'd12, 4'd10, 4'd9, 4'd0};
    logic [3:0] ld_exp [4] = '{4'd9,  4'd9,  4'd9, 4'd0};
    // C is up-counting with pcnt=0 here; park it at 9 so the step edge would wrap.
    c_load = 1; c_data = 4'd9;
    @(negedge CLK);
    c_load = 0;
    repeat (3) @(negedge CLK);
    c_load = 1; c_data = 4'd5;
    @(negedge CLK);
    c_load = 0;
    n_chk++;
    if ({c_q, c_c} !== {4'd5, 1'b0}) begin
      n_fail++;
      $display("FAIL load_on_step: q=%0d c=%b want q=5 c=0", c_q, c_c);
    end
    repeat (3) @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd5) begin
      n_fail++;
      $display("FAIL load_prescale_restart: q=%0d want 5", c_q);
    end
    @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd6) begin
      n_fail++;
      $display("FAIL load_next_step: q=%0d want 6", c_q);
    end
    c_en = 0;
    b_en = 0;
    for (int i = 0; i < 4; i++) begin
      b_load = 1; b_data = ld_in[i];
      @(negedge CLK);
      n_chk++;
      if ({b_q, b_c} !== {ld_exp[i], 1'b0}) begin
        n_fail++;
        $display("FAIL load_clamp in=%0d: q=%0d c=%b want q=%0d c=0", ld_in[i], b_q, b_c, ld_exp[i]);
      end
    end
    b_load = 0;
  endtask

  task automatic test_display();
    b_en = 0;
    for (int i = 0; i < 10; i++) begin
      b_load = 1; b_data = 4'(i);
      @(negedge CLK);
      n_chk++;
      if (b_d !== seg[i]) begin
        n_fail++;
        $display("FAIL display digit%0d: d=%b want %b", i, b_d, seg[i]);
      end
    end
    b_load = 0;
  endtask

  task automatic test_dir_flip();
    do_reset();
    a_en = 1; a_up = 1;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (a_q !== 3'd3) begin
      n_fail++;
      $display("FAIL dir_up3: q=%0d want 3", a_q);
    end
    a_up = 0;
    @(negedge CLK);
    n_chk++;
    if ({a_q, a_c} !== {3'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL dir_flip: q=%0d c=%b want q=2 c=0", a_q, a_c);
    end
    repeat (2) @(negedge CLK);
    @(negedge CLK);
    n_chk++;
    if ({a_q, a_c} !== {3'd7, 1'b1}) begin
      n_fail++;
      $display("FAIL dir_borrow: q=%0d c=%b want q=7 c=1", a_q, a_c);
    end
    a_en = 0;
  endtask

  task automatic test_reset_mid_prescale();
    do_reset();
    c_en = 1; c_up = 1;
    repeat (2) @(negedge CLK);
    rst_n = 0;
    @(negedge CLK);
    rst_n = 1;
    repeat (3) @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_prescale_early: q=%0d want 0", c_q);
    end
    @(negedge CLK);
    n_chk++;
    if (c_q !== 4'd1) begin
      n_fail++;
      $display("FAIL rst_mid_prescale_step: q=%0d want 1", c_q);
    end
    c_en = 0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_borrow();
    test_prescaler();
    test_load();
    test_display();
    test_dir_flip();
    test_reset_mid_prescale();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
